pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters SHALL be: BALL_SPEED, default 2, ball pixels per frame per axis; PAD_SPEED, default 4, paddle pixels per frame; SERVE_FRAMES, default 60, frames held before launch; WIN_SCORE, default 9, points to win.
REQ-002 Reset is clr, asynchronous, active-high; clock is dclk.
REQ-003 Ports SHALL be, in order:
- dclk in 1: 25 MHz pixel clock.
- clr in 1: asynchronous reset.
- vsync in 1: active-low sync from the display timing block.
- p1_up, p1_dn, p2_up, p2_dn in 1 each: debounced levels.
- serve in 1: debounced level.
- ballX out 10, ballY out 9: ball centre.
- paddle1Y, paddle2Y out 9: paddle centres.
- score1, score2 out 4: player scores.
- game_over out 1: high in GAMEOVER.
- state out 3: FSM state encoding.
REQ-004 All coordinates SHALL be in raw counter space: active x 144..783, active y 31..510.

Function
REQ-005 frame_tick SHALL be a one-dclk pulse on each synchronised falling edge of vsync, using a 2-flop sync plus edge detect.
REQ-006 All position, score and state registers SHALL update only on the cycle after frame_tick, so they are stable through each active frame.
REQ-007 The FSM SHALL have states IDLE, SERVE, PLAY, POINT and GAMEOVER; serve_rise is the rising edge of synchronised serve.
REQ-008 State transitions SHALL be:
- IDLE→SERVE on serve_rise.
- SERVE→PLAY after SERVE_FRAMES frame_ticks.
- PLAY→POINT on a miss.
- POINT→GAMEOVER on the next frame_tick if either score equals WIN_SCORE, otherwise POINT→SERVE.
- GAMEOVER→SERVE on serve_rise, clearing both scores.
REQ-009 In IDLE, SERVE and POINT the ball SHALL be held at (464,271).
REQ-010 On entry to SERVE, dy SHALL toggle.
REQ-011 dx on entry to SERVE SHALL point toward the player who lost the last point, and right after reset.
REQ-012 Paddles SHALL move by PAD_SPEED per frame in every state except GAMEOVER.
REQ-013 A paddle SHALL move up when only its up input is high, down when only its down input is high, and not at all when both or neither are high.
REQ-014 Paddle centre SHALL be clamped to 63..478.
REQ-015 In PLAY, each frame the next ball position SHALL be nx = ballX ± BALL_SPEED and ny = ballY ± BALL_SPEED; the comparisons SHALL use 11-bit signed arithmetic with no wrap.
REQ-016 Vertical bounce: if ny ≤ 39 then ny = 39 and dy = down; if ny ≥ 502 then ny = 502 and dy = up.
REQ-017 Left hit: if dx = left, ballX > 176, nx ≤ 176 and |ballY − paddle1Y| ≤ 40, then nx = 176 and dx = right.
REQ-018 Right hit: if dx = right, ballX < 768, nx ≥ 768 and |ballY − paddle2Y| ≤ 40, then nx = 768 and dx = left.
REQ-019 Miss: otherwise, nx ≤ 152 SHALL increment score2, and nx ≥ 775 SHALL increment score1; either SHALL enter POINT.
REQ-020 Scores SHALL saturate at 15.
REQ-021 When a vertical bounce and a paddle hit occur in the same frame, both SHALL apply.
REQ-022 A hit check SHALL take priority over a miss check in the same frame.
REQ-023 In GAMEOVER, game_over SHALL be 1, and all positions and scores SHALL be frozen.

Reset
REQ-024 clr SHALL force, mid-frame or mid-play:
- state = IDLE, ballX = 464, ballY = 271.
- paddle1Y = paddle2Y = 271.
- score1 = score2 = 0, game_over = 0.
- dx = right, dy = down.
- serve counter = 0, sync/edge flops = 1.
REQ-025 The first frame_tick SHALL NOT be generated until a falling edge of vsync is seen after reset release.

Configuration
REQ-026 With PONG_AI_EN defined, p2_up and p2_dn SHALL be ignored, and paddle2 SHALL move PAD_SPEED toward ballY each frame when |ballY − paddle2Y| > PAD_SPEED, with the same clamp.
REQ-027 Without PONG_AI_EN, paddle2 SHALL be driven by p2_up and p2_dn.

Structure
REQ-028 A shared package pong_pkg SHALL hold:
- the state enum;
- the screen-bound constants (144, 783, 31, 510);
- the centre constants (464, 271);
- the paddle constants (x 160..168, 776..784, half-height 32, hit window 40);
- the ball radius 8 and the clamp limits.
REQ-029 Sub-module pong_paddle SHALL contain the up/down/clamp logic plus the enable input, and SHALL be instantiated twice.

Verification
REQ-030 Reset: assert clr mid-PLAY → all outputs return to reset values within the same cycle, and stay stable until frames resume.
REQ-031 Serve: serve pulse in IDLE → state SERVE; after exactly 60 vsync falls, state = PLAY and ballX = 466 on the next frame.
REQ-032 Wall bounce: ballY = 40, dy = up, PLAY → next frame ballY = 39 and dy = down.
REQ-033 Paddle hit: ballX = 178, dx = left, ballY = paddle1Y + 40 → ballX = 176 and dx = right; with ballY = paddle1Y + 41 → the ball continues, and reaching ballX ≤ 152 increments score2 and enters POINT.
REQ-034 Game over: score1 = 8 and a right miss → score1 = 9, then GAMEOVER on the next frame with game_over = 1; serve_rise → scores 0, state SERVE.
REQ-035 Paddle clamp: p1_dn and p1_up both high → paddle1Y unchanged; p1_dn held 200 frames → paddle1Y = 478.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared state encoding and playfield geometry for the pong controller.
// All coordinates are raw display-counter values held as 11-bit signed.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  typedef logic signed [10:0] coord_t;

  localparam coord_t SCR_X0 = 11'sd144;
  localparam coord_t SCR_X1 = 11'sd783;
  localparam coord_t SCR_Y0 = 11'sd31;
  localparam coord_t SCR_Y1 = 11'sd510;

  localparam logic [9:0] CTR_X = 10'd464;
  localparam logic [8:0] CTR_Y = 9'd271;

  localparam coord_t PAD1_X0  = 11'sd160;
  localparam coord_t PAD1_X1  = 11'sd168;
  localparam coord_t PAD2_X0  = 11'sd776;
  localparam coord_t PAD2_X1  = 11'sd784;
  localparam coord_t PAD_HALF = 11'sd32;
  localparam coord_t HIT_WIN  = 11'sd40;
  localparam coord_t BALL_R   = 11'sd8;

  // Limits the ball centre and paddle centre may reach, derived from the geometry.
  localparam coord_t WALL_TOP = SCR_Y0 + BALL_R;
  localparam coord_t WALL_BOT = SCR_Y1 - BALL_R;
  localparam coord_t HIT_L    = PAD1_X1 + BALL_R;
  localparam coord_t HIT_R    = PAD2_X0 - BALL_R;
  localparam coord_t MISS_L   = SCR_X0 + BALL_R;
  localparam coord_t MISS_R   = SCR_X1 - BALL_R;
  localparam coord_t PAD_MIN  = SCR_Y0 + PAD_HALF;
  localparam coord_t PAD_MAX  = SCR_Y1 - PAD_HALF;

  function automatic coord_t absdiff(input coord_t a, input coord_t b);
    coord_t d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: moves PAD_SPEED per enabled frame on a lone up or down
// request, with its centre clamped to the playfield limits.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PAD_SPEED = 4
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [8:0] pos
);

  coord_t cur;
  coord_t nxt;

  always_comb begin
    cur = coord_t'({2'b00, pos});
    nxt = cur;
    if (up && !dn) begin
      nxt = cur - coord_t'(PAD_SPEED);
      if (nxt < PAD_MIN) nxt = PAD_MIN;
    end else if (dn && !up) begin
      nxt = cur + coord_t'(PAD_SPEED);
      if (nxt > PAD_MAX) nxt = PAD_MAX;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) pos <= CTR_Y;
    else if (en) pos <= nxt[8:0];
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: frame-synchronous ball, paddle, score and game FSM.
// Define PONG_AI_EN to have paddle2 track the ball instead of p2_up/p2_dn.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       vsync,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       serve,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic [8:0] paddle1Y,
  output logic [8:0] paddle2Y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [2:0] state
);

  state_t      st;
  logic        vs_s1, vs_s2, vs_d;
  logic        sv_s1, sv_s2, sv_d, serve_pend;
  logic        frame_tick, serve_rise, serve_go;
  logic        dx, dy;            // dx: 1 = right, dy: 1 = down
  logic [15:0] serve_cnt;
  logic        pad_en, p2u, p2d;
  coord_t      bx, by, p1c, p2c, nx, ny;
  logic        ndx, ndy, miss_l, miss_r;

  // A serve press may land anywhere in the frame; hold it until the next tick.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      {vs_s1, vs_s2, vs_d} <= '1;
      {sv_s1, sv_s2, sv_d} <= '0;
      serve_pend           <= 1'b0;
    end else begin
      vs_s1      <= vsync;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      sv_s1      <= serve;
      sv_s2      <= sv_s1;
      sv_d       <= sv_s2;
      serve_pend <= frame_tick ? 1'b0 : (serve_pend | serve_rise);
    end
  end

  assign frame_tick = vs_d & ~vs_s2;
  assign serve_rise = sv_s2 & ~sv_d;
  assign serve_go   = serve_pend | serve_rise;
  assign pad_en     = frame_tick && (st != ST_GAMEOVER);
  assign state      = st;

  assign bx  = coord_t'({1'b0, ballX});
  assign by  = coord_t'({2'b00, ballY});
  assign p1c = coord_t'({2'b00, paddle1Y});
  assign p2c = coord_t'({2'b00, paddle2Y});

  always_comb begin
    nx     = dx ? bx + coord_t'(BALL_SPEED) : bx - coord_t'(BALL_SPEED);
    ny     = dy ? by + coord_t'(BALL_SPEED) : by - coord_t'(BALL_SPEED);
    ndx    = dx;
    ndy    = dy;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (ny <= WALL_TOP) begin
      ny  = WALL_TOP;
      ndy = 1'b1;
    end else if (ny >= WALL_BOT) begin
      ny  = WALL_BOT;
      ndy = 1'b0;
    end
    // Paddle hits are tested first so a returned ball never scores.
    if (!dx && bx > HIT_L && nx <= HIT_L && absdiff(by, p1c) <= HIT_WIN) begin
      nx  = HIT_L;
      ndx = 1'b1;
    end else if (dx && bx < HIT_R && nx >= HIT_R && absdiff(by, p2c) <= HIT_WIN) begin
      nx  = HIT_R;
      ndx = 1'b0;
    end else begin
      miss_l = (nx <= MISS_L);
      miss_r = (nx >= MISS_R);
    end
  end

`ifdef PONG_AI_EN
  always_comb begin
    p2u = (p2c - by) > coord_t'(PAD_SPEED);
    p2d = (by - p2c) > coord_t'(PAD_SPEED);
  end
`else
  assign p2u = p2_up;
  assign p2d = p2_dn;
`endif

  pong_paddle #(.PAD_SPEED(PAD_SPEED)) u_pad1 (
    .dclk(dclk), .clr(clr), .en(pad_en), .up(p1_up), .dn(p1_dn), .pos(paddle1Y)
  );

  pong_paddle #(.PAD_SPEED(PAD_SPEED)) u_pad2 (
    .dclk(dclk), .clr(clr), .en(pad_en), .up(p2u), .dn(p2d), .pos(paddle2Y)
  );

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      st        <= ST_IDLE;
      ballX     <= CTR_X;
      ballY     <= CTR_Y;
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= '0;
    end else if (frame_tick) begin
      unique case (st)
        ST_IDLE: begin
          if (serve_go) begin
            st        <= ST_SERVE;
            dy        <= ~dy;
            serve_cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (serve_cnt == 16'(SERVE_FRAMES - 1)) begin
            st        <= ST_PLAY;
            serve_cnt <= '0;
          end else begin
            serve_cnt <= serve_cnt + 16'd1;
          end
        end
        ST_PLAY: begin
          dy <= ndy;
          // dx after a miss points at the player who just lost the point.
          if (miss_l || miss_r) begin
            st    <= ST_POINT;
            ballX <= CTR_X;
            ballY <= CTR_Y;
            if (miss_l) begin
              score2 <= (score2 == 4'hf) ? score2 : score2 + 4'd1;
              dx     <= 1'b0;
            end else begin
              score1 <= (score1 == 4'hf) ? score1 : score1 + 4'd1;
              dx     <= 1'b1;
            end
          end else begin
            ballX <= nx[9:0];
            ballY <= ny[8:0];
            dx    <= ndx;
          end
        end
        ST_POINT: begin
          if (score1 == 4'(WIN_SCORE) || score2 == 4'(WIN_SCORE)) begin
            st        <= ST_GAMEOVER;
            game_over <= 1'b1;
          end else begin
            st        <= ST_SERVE;
            dy        <= ~dy;
            serve_cnt <= '0;
          end
        end
        ST_GAMEOVER: begin
          if (serve_go) begin
            st        <= ST_SERVE;
            game_over <= 1'b0;
            score1    <= '0;
            score2    <= '0;
            dy        <= ~dy;
            serve_cnt <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: frame-level game model with randomized paddle play,
// compared against the DUT after every frame, plus literal checkpoints.
module tb_pong_game_ctrl;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_GO = 4;
  localparam int BS = 2, PS = 4, NSERVE = 60, WIN = 9;

  logic       dclk = 1'b0;
  logic       clr, vsync, p1_up, p1_dn, p2_up, p2_dn, serve;
  logic [9:0] ballX;
  logic [8:0] ballY, paddle1Y, paddle2Y;
  logic [3:0] score1, score2;
  logic       game_over;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int frame_no = 0;

  // Model: ball velocity signs m_vx/m_vy are +1 (right/down) or -1.
  int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_st, m_vx, m_vy, m_cnt, m_pend;

  pong_game_ctrl #(
    .BALL_SPEED(BS), .PAD_SPEED(PS), .SERVE_FRAMES(NSERVE), .WIN_SCORE(WIN)
  ) dut (
    .dclk(dclk), .clr(clr), .vsync(vsync),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .serve(serve),
    .ballX(ballX), .ballY(ballY), .paddle1Y(paddle1Y), .paddle2Y(paddle2Y),
    .score1(score1), .score2(score2), .game_over(game_over), .state(state)
  );

  always #20 dclk = ~dclk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pad_move(input int p, input logic u, input logic d);
    if (u && !d) return (p - PS < 63) ? 63 : p - PS;
    if (d && !u) return (p + PS > 478) ? 478 : p + PS;
    return p;
  endfunction

  task automatic model_reset();
    m_bx = 464; m_by = 271; m_p1 = 271; m_p2 = 271;
    m_s1 = 0; m_s2 = 0; m_st = S_IDLE;
    m_vx = 1; m_vy = 1; m_cnt = 0; m_pend = 0;
  endtask

  task automatic enter_serve();
    m_st = S_SERVE; m_vy = -m_vy; m_cnt = 0; m_bx = 464; m_by = 271;
  endtask

  task automatic model_play(input int op1, input int op2);
    int nx, ny;
    nx = m_bx + BS * m_vx;
    ny = m_by + BS * m_vy;
    if (ny <= 39) begin ny = 39; m_vy = 1; end
    else if (ny >= 502) begin ny = 502; m_vy = -1; end
    if (m_vx < 0 && m_bx > 176 && nx <= 176 && iabs(m_by - op1) <= 40) begin
      nx = 176; m_vx = 1;
    end else if (m_vx > 0 && m_bx < 768 && nx >= 768 && iabs(m_by - op2) <= 40) begin
      nx = 768; m_vx = -1;
    end else if (nx <= 152) begin
      m_s2 = (m_s2 + 1 > 15) ? 15 : m_s2 + 1; m_vx = -1; m_st = S_POINT;
    end else if (nx >= 775) begin
      m_s1 = (m_s1 + 1 > 15) ? 15 : m_s1 + 1; m_vx = 1; m_st = S_POINT;
    end
    if (m_st == S_POINT) begin m_bx = 464; m_by = 271; end
    else begin m_bx = nx; m_by = ny; end
  endtask

  task automatic model_frame(input logic u1, input logic d1, input logic u2, input logic d2);
    int op1, op2, ost;
    op1 = m_p1; op2 = m_p2; ost = m_st;
    case (m_st)
      S_IDLE:  if (m_pend != 0) enter_serve();
      S_SERVE: begin m_cnt++; if (m_cnt == NSERVE) m_st = S_PLAY; end
      S_PLAY:  model_play(op1, op2);
      S_POINT: if (m_s1 == WIN || m_s2 == WIN) m_st = S_GO; else enter_serve();
      default: if (m_pend != 0) begin m_s1 = 0; m_s2 = 0; enter_serve(); end
    endcase
    if (ost != S_GO) begin
      m_p1 = pad_move(op1, u1, d1);
      m_p2 = pad_move(op2, u2, d2);
    end
    m_pend = 0;
  endtask

  task automatic check_model(input string tag);
    tests++;
    if (int'(state) != m_st || int'(ballX) != m_bx || int'(ballY) != m_by ||
        int'(paddle1Y) != m_p1 || int'(paddle2Y) != m_p2 || int'(score1) != m_s1 ||
        int'(score2) != m_s2 || int'(game_over) != int'(m_st == S_GO)) begin
      fails++;
      $display("FAIL %s frame %0d: got st=%0d bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d go=%0d, want st=%0d bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d go=%0d",
               tag, frame_no, state, ballX, ballY, paddle1Y, paddle2Y, score1, score2, game_over,
               m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, int'(m_st == S_GO));
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic run_frame(input logic u1, input logic d1, input logic u2, input logic d2);
    @(negedge dclk);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    vsync = 1'b0;
    model_frame(u1, d1, u2, d2);
    frame_no++;
    repeat (2) @(negedge dclk);
    vsync = 1'b1;
    repeat (4) @(negedge dclk);
    check_model("frame");
  endtask

  task automatic run_random_frame();
    logic u1, d1, u2, d2;
    if ($urandom_range(3) == 0) begin u1 = m_by < m_p1; d1 = m_by > m_p1; end
    else begin u1 = 1'($urandom); d1 = 1'($urandom); end
    if ($urandom_range(3) == 0) begin u2 = m_by < m_p2; d2 = m_by > m_p2; end
    else begin u2 = 1'($urandom); d2 = 1'($urandom); end
    run_frame(u1, d1, u2, d2);
  endtask

  task automatic do_serve();
    @(negedge dclk); serve = 1'b1;
    repeat (4) @(negedge dclk); serve = 1'b0;
    repeat (4) @(negedge dclk);
    m_pend = 1;
  endtask

  task automatic check_reset_lits(input string tag);
    check_lit({tag, "_state"}, int'(state), S_IDLE);
    check_lit({tag, "_ballX"}, int'(ballX), 464);
    check_lit({tag, "_ballY"}, int'(ballY), 271);
    check_lit({tag, "_pad1"}, int'(paddle1Y), 271);
    check_lit({tag, "_pad2"}, int'(paddle2Y), 271);
    check_lit({tag, "_scores"}, int'(score1) + int'(score2), 0);
    check_lit({tag, "_gameover"}, int'(game_over), 0);
  endtask

  initial begin
    int guard;
    clr = 1'b1; vsync = 1'b1; serve = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    repeat (3) @(negedge dclk);
    check_reset_lits("rst");
    clr = 1'b0;
    model_reset();
    repeat (4) @(negedge dclk);

    repeat (5) run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check_lit("pad1_both_held", int'(paddle1Y), 271);
    repeat (200) run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_lit("pad1_clamp_bottom", int'(paddle1Y), 478);
    repeat (120) run_frame(1'b1, 1'b0, 1'b1, 1'b0);
    check_lit("pad1_clamp_top", int'(paddle1Y), 63);
    check_lit("pad2_clamp_top", int'(paddle2Y), 63);

    do_serve();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("serve_state", int'(state), S_SERVE);
    repeat (NSERVE) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("launch_state", int'(state), S_PLAY);
    check_lit("launch_ballX", int'(ballX), 464);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("first_move_ballX", int'(ballX), 466);
    check_lit("first_move_ballY", int'(ballY), 269);

    repeat (20) run_random_frame();
    @(posedge dclk); #3 clr = 1'b1;
    #1 check_reset_lits("midplay_rst");
    repeat (3) @(negedge dclk);
    clr = 1'b0;
    model_reset();
    repeat (10) @(negedge dclk);
    check_model("post_reset_hold");

    do_serve();
    guard = 0;
    while (m_st != S_GO && guard < 12000) begin
      run_random_frame();
      guard++;
    end
    check_lit("game_reached_gameover", int'(m_st == S_GO), 1);
    check_lit("gameover_flag", int'(game_over), 1);
    check_lit("winner_score", (score1 > score2) ? int'(score1) : int'(score2), WIN);
    repeat (5) run_random_frame();

    do_serve();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_lit("restart_score1", int'(score1), 0);
    check_lit("restart_score2", int'(score2), 0);
    check_lit("restart_state", int'(state), S_SERVE);
    check_lit("restart_gameover", int'(game_over), 0);
    repeat (10) run_random_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
